ffpc_bank_ctrl: RTL and testbench

FFPC_BANK_CTRL -- requirements
Module: ffpc_bank_ctrl

---
 rtl/ffpc_pkg.sv | 20 ++
 rtl/ffpc_bit.sv | 18 +
 rtl/ffpc_bank_ctrl.sv | 121 ++++++++++++
 tb/tb_ffpc_bank_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ffpc_pkg.sv
// Shared definitions for the preset/clear flop bank controller:
// command encodings, FSM state encoding and the default bank width.
package ffpc_pkg;

  localparam int FFPC_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    CMD_LOAD   = 2'b00,
    CMD_CLEAR  = 2'b01,
    CMD_PRESET = 2'b10,
    CMD_SHIFT  = 2'b11
  } ffpc_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_ACK   = 2'b10
  } ffpc_state_e;

endpackage

// File: rtl/ffpc_bit.sv
// One cell of the bank: D flop with synchronous active-low preset and
// clear. Preset wins over clear, clear wins over D.
module ffpc_bit (
  input  logic clk,
  input  logic PR_L,
  input  logic CLR_L,
  input  logic D,
  output logic Q
);

  // Cell update with preset > clear > D priority.
  always_ff @(posedge clk) begin
    if (!PR_L)       Q <= 1'b1;
    else if (!CLR_L) Q <= 1'b0;
    else             Q <= D;
  end

endmodule

// File: rtl/ffpc_bank_ctrl.sv
// Two-requester controller for a bank of preset/clear flops.
// Handshake: a requester raises req (level) with cmd/data and holds them
// stable until its one-cycle ack; a transaction is accepted only in IDLE,
// q shows the result in the ack cycle, and a req still high afterwards is
// a new transaction. Ties are resolved round-robin.
// Optional feature: define FFPC_BANK_CTRL_OPCNT_EN to add the 8-bit
// ops_cnt output counting completed transactions (wraps 255 -> 0).
module ffpc_bank_ctrl
  import ffpc_pkg::*;
#(
  parameter int WIDTH = FFPC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             RST_L,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       cmd0,
  input  logic [1:0]       cmd1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] q,
  output logic             busy,
`ifdef FFPC_BANK_CTRL_OPCNT_EN
  output logic [7:0]       ops_cnt,
`endif
  output ffpc_state_e      dbg_state
);

  ffpc_state_e      state_q, state_d;
  logic             gnt_q;       // requester owning the current transaction
  logic             last_q;      // requester served most recently
  ffpc_cmd_e        cmd_q;
  logic [WIDTH-1:0] data_q;
  logic             grant_sel;
  logic             accept;

  logic [WIDTH-1:0] pr_l;
  logic [WIDTH-1:0] clr_l;
  logic [WIDTH-1:0] d;

  assign accept    = (state_q == ST_IDLE) && (req0 || req1);
  // With both requesting, the one not served last wins; otherwise the sole requester.
  assign grant_sel = (req0 && req1) ? ~last_q : req1;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req0 || req1) state_d = ST_APPLY;
      ST_APPLY: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register plus the captured transaction (taken at the accept edge).
  always_ff @(posedge clk) begin
    if (!RST_L) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cmd_q   <= CMD_LOAD;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q  <= grant_sel;
        last_q <= grant_sel;
        cmd_q  <= grant_sel ? ffpc_cmd_e'(cmd1) : ffpc_cmd_e'(cmd0);
        data_q <= grant_sel ? data1 : data0;
      end
    end
  end

  // Cell controls: hold q except during APPLY; reset clears the bank.
  always_comb begin
    pr_l  = '1;
    clr_l = '1;
    d     = q;
    if (!RST_L) begin
      clr_l = '0;
    end else if (state_q == ST_APPLY) begin
      case (cmd_q)
        CMD_CLEAR:  clr_l = '0;
        CMD_PRESET: pr_l  = '0;
        CMD_LOAD:   d     = data_q;
        CMD_SHIFT: begin
          d    = q << 1;
          d[0] = data_q[0];
        end
        default:    d     = q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    ffpc_bit u_bit (
      .clk   (clk),
      .PR_L  (pr_l[i]),
      .CLR_L (clr_l[i]),
      .D     (d[i]),
      .Q     (q[i])
    );
  end

  assign ack0      = (state_q == ST_ACK) && !gnt_q;
  assign ack1      = (state_q == ST_ACK) &&  gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

`ifdef FFPC_BANK_CTRL_OPCNT_EN
  // Count each ack cycle; natural 8-bit wrap.
  always_ff @(posedge clk) begin
    if (!RST_L)                 ops_cnt <= 8'd0;
    else if (state_q == ST_ACK) ops_cnt <= ops_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ffpc_bank_ctrl.sv
// Directed testbench for ffpc_bank_ctrl. Inputs change and outputs are
// sampled on the falling edge; the design acts on the rising edge.
module tb_ffpc_bank_ctrl;
  import ffpc_pkg::*;

  localparam int WIDTH = 8;

  // Clock and reset
  logic             clk = 1'b0;
  logic             RST_L = 1'b0;
  always #5 clk = ~clk;

  logic             req0 = 1'b0, req1 = 1'b0;
  logic [1:0]       cmd0 = 2'b00, cmd1 = 2'b00;
  logic [WIDTH-1:0] data0 = '0, data1 = '0;
  logic             ack0, ack1, busy;
  logic [WIDTH-1:0] q;
  ffpc_state_e      dbg_state;
`ifdef FFPC_BANK_CTRL_OPCNT_EN
  logic [7:0]       ops_cnt;
`endif

  ffpc_bank_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .RST_L     (RST_L),
    .req0      (req0),
    .req1      (req1),
    .cmd0      (cmd0),
    .cmd1      (cmd1),
    .data0     (data0),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .q         (q),
    .busy      (busy),
`ifdef FFPC_BANK_CTRL_OPCNT_EN
    .ops_cnt   (ops_cnt),
`endif
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard queues for the round-robin scenario
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_gnt_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ack0"}, 32'(ack0), 32'd0);
    chk({tag, "_ack1"}, 32'(ack1), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Driver: one full transaction from the given requester, checking each cycle.
  task automatic run_txn(input string tag, input logic who, input logic [1:0] cmd,
                         input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] exp_val,
                         input logic [WIDTH-1:0] prev_val);
    if (who) begin req1 = 1'b1; cmd1 = cmd; data1 = data; end
    else     begin req0 = 1'b1; cmd0 = cmd; data0 = data; end
    tick();  // APPLY
    chk({tag, "_apply_busy"}, 32'(busy), 32'd1);
    chk({tag, "_apply_q"}, 32'(q), 32'(prev_val));
    chk({tag, "_apply_noack"}, 32'({ack1, ack0}), 32'd0);
    tick();  // ACK
    chk({tag, "_q"}, 32'(q), 32'(exp_val));
    chk({tag, "_acks"}, 32'({ack1, ack0}), who ? 32'd2 : 32'd1);
    chk({tag, "_ack_busy"}, 32'(busy), 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();  // back in IDLE
    chk_idle({tag, "_done"});
    chk({tag, "_hold_q"}, 32'(q), 32'(exp_val));
  endtask

  initial begin
    int acks;
    logic [WIDTH-1:0] eq;
    logic eg;

    // Reset state
    tick();
    tick();
    chk("rst_q", 32'(q), 32'd0);
    chk_idle("rst");
    RST_L = 1'b1;
    tick();
    chk_idle("post_rst");

    // LOAD A5 from requester 0, SHIFT in a 1 from requester 1
    run_txn("load_a5", 1'b0, 2'b00, 8'hA5, 8'hA5, 8'h00);
    run_txn("shift", 1'b1, 2'b11, 8'h01, 8'h4B, 8'hA5);
    // PRESET then CLEAR from requester 0; SHIFT in a 0 from requester 1
    run_txn("preset", 1'b0, 2'b10, 8'h00, 8'hFF, 8'h4B);
    run_txn("shift0", 1'b1, 2'b11, 8'hFE, 8'hFE, 8'hFF);
    run_txn("clear", 1'b0, 2'b01, 8'hFF, 8'h00, 8'hFE);
    run_txn("load_1", 1'b1, 2'b00, 8'h5A, 8'h5A, 8'h00);

    // Both requesting after reset: grants alternate 0,1,0
    RST_L = 1'b0;
    tick();
    chk("rr_rst_q", 32'(q), 32'd0);
    RST_L = 1'b1;
    exp_q.push_back(8'h11); exp_gnt_q.push_back(1'b0);
    exp_q.push_back(8'h22); exp_gnt_q.push_back(1'b1);
    exp_q.push_back(8'h11); exp_gnt_q.push_back(1'b0);
    req0 = 1'b1; cmd0 = 2'b00; data0 = 8'h11;
    req1 = 1'b1; cmd1 = 2'b00; data1 = 8'h22;
    for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
      tick();
      chk("rr_no_dual_ack", 32'(ack0 & ack1), 32'd0);
      if (ack0 || ack1) begin
        eq = exp_q.pop_front();
        eg = exp_gnt_q.pop_front();
        chk("rr_grant", 32'(ack1), 32'(eg));
        chk("rr_q", 32'(q), 32'(eq));
      end
    end
    chk("rr_timeout", 32'(exp_q.size()), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk_idle("rr_end");

    // Reset during APPLY of LOAD 3C aborts without ack
    req0 = 1'b1; cmd0 = 2'b00; data0 = 8'h3C;
    tick();
    chk("abort_apply_busy", 32'(busy), 32'd1);
    RST_L = 1'b0;
    req0 = 1'b0;
    tick();
    chk("abort_q", 32'(q), 32'd0);
    chk_idle("abort");
    RST_L = 1'b1;
    tick();
    chk_idle("abort_after");
    chk("abort_after_q", 32'(q), 32'd0);

`ifdef FFPC_BANK_CTRL_OPCNT_EN
    // 256 back-to-back transactions wrap the counter
    chk("cnt_rst", 32'(ops_cnt), 32'd0);
    acks = 0;
    req0 = 1'b1; cmd0 = 2'b01; data0 = 8'h00;
    for (int cyc = 0; cyc < 1000 && acks < 256; cyc++) begin
      tick();
      if (ack0) begin
        chk("cnt_val", 32'(ops_cnt), 32'(acks));
        acks++;
        if (acks == 256) req0 = 1'b0;
      end
    end
    chk("cnt_acks", 32'(acks), 32'd256);
    tick();
    chk("cnt_wrap", 32'(ops_cnt), 32'd0);
    chk_idle("cnt_end");
`else
    acks = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
